// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundle of requester handshakes and RAM-side signals
// for the three-port RAM arbiter.
//
// Ports / signal groups:
//   fetch   : req_f, addr_f                           (read-only requester)
//   data    : req_d, we_d, addr_d, wdata_d            (load/store requester)
//   debug   : req_x, we_x, addr_x, wdata_x            (debug/DMA requester)
//   status  : gnt_f/d/x, done_f/d/x, rdata, busy      (arbiter -> requesters)
//   ram     : ram_en, ram_we, ram_addr, ram_wdata     (arbiter -> RAM)
//             ram_rdata                               (RAM -> arbiter)
//
// Modports:
//   master : requester/RAM environment side
//   slave  : the arbiter itself
interface ram_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              req_f;
  logic [ADDR_W-1:0] addr_f;

  logic              req_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  logic              req_x;
  logic              we_x;
  logic [ADDR_W-1:0] addr_x;
  logic [DATA_W-1:0] wdata_x;

  logic              gnt_f;
  logic              gnt_d;
  logic              gnt_x;
  logic              done_f;
  logic              done_d;
  logic              done_x;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output req_f, addr_f,
    output req_d, we_d, addr_d, wdata_d,
    output req_x, we_x, addr_x, wdata_x,
    input  gnt_f, gnt_d, gnt_x, done_f, done_d, done_x, rdata, busy,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  req_f, addr_f,
    input  req_d, we_d, addr_d, wdata_d,
    input  req_x, we_x, addr_x, wdata_x,
    output gnt_f, gnt_d, gnt_x, done_f, done_d, done_x, rdata, busy,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM (1-cycle read
// latency) between a fetch port, a load/store port and a debug/DMA port.
// One transaction at a time: IDLE -> ISSUE -> (WAIT for reads) -> DONE.
// Priority is D > F > X, but the debug port wins outright once it has
// been passed over XAGE_MAX times.
//
// Ports:
//   Clock : system clock, all state on the rising edge
//   Reset : asynchronous active-low reset
//   Run   : CPU running; when low the fetch and data ports are masked
//   bus   : ram_arbiter_if.slave (requests, grants, done pulses, rdata,
//           busy and the RAM-side signals)
module ram_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int XAGE_MAX = 3
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Run,
  ram_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] XAGE_LIM = 2'(XAGE_MAX);

  logic [1:0]        state;
  // One-hot winner {x, d, f}; nonzero only while a transaction is active.
  logic [2:0]        grant;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic [1:0]        xage;
  logic [DATA_W-1:0] rdata_q;

  logic              elig_f;
  logic              elig_d;
  logic              elig_x;
  logic [2:0]        pick;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [DATA_W-1:0] sel_wdata;

  // Arbitration: a starved debug port overrides the fixed priority.
  always_comb begin
    elig_f = bus.req_f & Run;
    elig_d = bus.req_d & Run;
    elig_x = bus.req_x;
    pick   = 3'b000;
    if (elig_x && (xage == XAGE_LIM))
      pick = 3'b100;
    else if (elig_d)
      pick = 3'b010;
    else if (elig_f)
      pick = 3'b001;
    else if (elig_x)
      pick = 3'b100;
  end

  // Winner's request fields; fetch is always a read.
  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    case (pick)
      3'b001: begin
        sel_addr = bus.addr_f;
      end
      3'b010: begin
        sel_addr  = bus.addr_d;
        sel_we    = bus.we_d;
        sel_wdata = bus.wdata_d;
      end
      3'b100: begin
        sel_addr  = bus.addr_x;
        sel_we    = bus.we_x;
        sel_wdata = bus.wdata_x;
      end
      default: begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_wdata = '0;
      end
    endcase
  end

  // Transaction sequencer. Requests are only looked at in IDLE, and
  // everything the transaction needs is latched on acceptance so that
  // requesters may drop or change their inputs afterwards.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      grant     <= 3'b000;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      xage      <= 2'd0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick != 3'b000) begin
            state     <= ISSUE;
            grant     <= pick;
            lat_addr  <= sel_addr;
            lat_we    <= sel_we;
            lat_wdata <= sel_wdata;
            if (pick[2])
              xage <= 2'd0;
            else if (bus.req_x && (xage < XAGE_LIM))
              xage <= xage + 2'd1;
          end
        end
        ISSUE: begin
          state <= lat_we ? DONE : WAIT;
        end
        WAIT: begin
          rdata_q <= bus.ram_rdata;
          state   <= DONE;
        end
        DONE: begin
          state <= IDLE;
          grant <= 3'b000;
        end
        default: begin
          state <= IDLE;
          grant <= 3'b000;
        end
      endcase
    end
  end

  // Outputs decode straight from state so that an asynchronous reset
  // drops them (including ram_we) immediately.
  assign bus.gnt_f     = grant[0];
  assign bus.gnt_d     = grant[1];
  assign bus.gnt_x     = grant[2];
  assign bus.done_f    = grant[0] & (state == DONE);
  assign bus.done_d    = grant[1] & (state == DONE);
  assign bus.done_x    = grant[2] & (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.rdata     = rdata_q;
  assign bus.ram_en    = (state == ISSUE);
  assign bus.ram_we    = (state == ISSUE) & lat_we;
  assign bus.ram_addr  = (state == ISSUE) ? lat_addr : '0;
  assign bus.ram_wdata = (state == ISSUE) ? lat_wdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter. A behavioural
// single-port RAM (1-cycle read latency) sits on the RAM side. Every
// accepted transaction pushes its expected outcome onto a scoreboard
// queue; a monitor pops and compares on each done pulse. Arbitration is
// exercised from a table of vectors, and latency, reset abort, mid-
// transaction request drop and debug-port starvation by hand sequences.
module tb_ram_arbiter;

  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 32;
  localparam int XAGE_MAX = 3;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic Run   = 1'b0;

  ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .XAGE_MAX(XAGE_MAX)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Run(Run),
    .bus(bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [1:0]  port;
    logic        we;
    logic [8:0]  addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        run, rf, rd, rx, wd, wx;
    logic [8:0]  af, ad, ax;
    logic [31:0] dd, dx;
    logic [2:0]  exp_gnt;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[12];
  logic [2:0]  starve_exp[8];
  logic [2:0]  g;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] mem[0:511];
  bit          written[0:511];
  logic [31:0] ram_q;
  logic [31:0] ref_mem[logic [8:0]];

  function automatic logic [31:0] default_word(input logic [8:0] a);
    return {16'hA5C3, 7'd0, a};
  endfunction

  function automatic logic [31:0] ram_word(input logic [8:0] a);
    return written[a] ? mem[a] : default_word(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [8:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : default_word(a);
  endfunction

  // Behavioural RAM: read data appears one clock after ram_en.
  always @(posedge Clock) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        mem[bus.ram_addr]     <= bus.ram_wdata;
        written[bus.ram_addr] <= 1'b1;
      end
      ram_q <= ram_word(bus.ram_addr);
    end
  end

  assign bus.ram_rdata = ram_q;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] port, input logic we, input logic [8:0] addr,
                          input logic [31:0] wdata);
    exp_t e;
    e.port = port;
    e.we   = we;
    e.addr = addr;
    if (we) begin
      ref_mem[addr] = wdata;
      e.data = wdata;
    end else begin
      e.data = ref_word(addr);
    end
    sb_q.push_back(e);
  endtask

  task automatic clear_reqs();
    bus.req_f   = 1'b0;
    bus.addr_f  = '0;
    bus.req_d   = 1'b0;
    bus.we_d    = 1'b0;
    bus.addr_d  = '0;
    bus.wdata_d = '0;
    bus.req_x   = 1'b0;
    bus.we_x    = 1'b0;
    bus.addr_x  = '0;
    bus.wdata_x = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || sb_q.size() != 0) && n < 20) begin
      @(negedge Clock);
      n++;
    end
    check_output("idle_timeout", 32'(n < 20), 32'd1);
  endtask

  // Drive one table vector in IDLE, check the grant after the accept
  // edge and queue the expected completion.
  task automatic apply_stimulus(input vec_t v);
    Run         = v.run;
    bus.req_f   = v.rf;
    bus.addr_f  = v.af;
    bus.req_d   = v.rd;
    bus.we_d    = v.wd;
    bus.addr_d  = v.ad;
    bus.wdata_d = v.dd;
    bus.req_x   = v.rx;
    bus.we_x    = v.wx;
    bus.addr_x  = v.ax;
    bus.wdata_x = v.dx;
    @(negedge Clock);
    check_output("vec_gnt", 32'({bus.gnt_x, bus.gnt_d, bus.gnt_f}), 32'(v.exp_gnt));
    case (v.exp_gnt)
      3'b001:  push_exp(2'd0, 1'b0, v.af, 32'd0);
      3'b010:  push_exp(2'd1, v.wd, v.ad, v.dd);
      3'b100:  push_exp(2'd2, v.wx, v.ax, v.dx);
      default: ;
    endcase
    clear_reqs();
    wait_idle();
  endtask

  // Scoreboard monitor: every done pulse must match the oldest
  // outstanding expectation.
  always @(negedge Clock) begin : monitor
    logic [2:0] done_v;
    logic [2:0] onehot;
    exp_t       e;
    if (Reset) begin
      done_v = {bus.done_x, bus.done_d, bus.done_f};
      if (done_v != 3'b000) begin
        if (sb_q.size() == 0) begin
          check_output("done_unexpected", 32'(done_v), 32'd0);
        end else begin
          e = sb_q.pop_front();
          onehot = 3'b001 << e.port;
          check_output("done_port", 32'(done_v), 32'(onehot));
          check_output("done_gnt", 32'({bus.gnt_x, bus.gnt_d, bus.gnt_f}), 32'(onehot));
          if (e.we)
            check_output("write_mem", ram_word(e.addr), e.data);
          else
            check_output("read_rdata", bus.rdata, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear_reqs();

    // run, rf, rd, rx, wd, wx, af, ad, ax, dd, dx, expected grant {x,d,f}
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 9'h010, 9'h000, 32'hDEADBEEF, 32'h0,        3'b010};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h010, 9'h000, 9'h000, 32'h0,        32'h0,        3'b001};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 9'h010, 9'h000, 32'h0,        32'h0,        3'b010};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h020, 9'h000, 9'h000, 32'h0,        32'h0,        3'b001};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h000, 9'h000, 9'h020, 32'h0,        32'h12345678, 3'b100};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'h010, 9'h010, 9'h020, 32'h0,        32'h0,        3'b100};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'h010, 9'h030, 9'h000, 32'h77777777, 32'h0,        3'b000};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000, 9'h1FF, 9'h000, 32'hCAFEF00D, 32'h0,        3'b010};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h1FF, 9'h000, 9'h000, 32'h0,        32'h0,        3'b001};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000, 9'h030, 9'h000, 32'h55AA55AA, 32'h0,        3'b010};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'h000, 9'h000, 9'h030, 32'h0,        32'h0,        3'b100};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 9'h000, 9'h1FF, 32'h0,        32'h0,        3'b100};

    starve_exp = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b010, 3'b010, 3'b010, 3'b100};

    // Reset state.
    @(negedge Clock);
    @(negedge Clock);
    check_output("reset_ctl", 32'({bus.gnt_x, bus.gnt_d, bus.gnt_f, bus.done_x, bus.done_d,
                                   bus.done_f, bus.busy, bus.ram_en, bus.ram_we}), 32'd0);
    check_output("reset_addr", 32'(bus.ram_addr), 32'd0);
    check_output("reset_wdata", bus.ram_wdata, 32'd0);
    check_output("reset_rdata", bus.rdata, 32'd0);
    Reset = 1'b1;
    @(negedge Clock);

    // Arbitration table.
    for (int i = 0; i < 12; i++)
      apply_stimulus(vecs[i]);

    // Write latency: one ISSUE cycle with ram_we, done the cycle after.
    Run         = 1'b1;
    bus.req_d   = 1'b1;
    bus.we_d    = 1'b1;
    bus.addr_d  = 9'h040;
    bus.wdata_d = 32'h0BADF00D;
    @(negedge Clock);
    push_exp(2'd1, 1'b1, 9'h040, 32'h0BADF00D);
    clear_reqs();
    check_output("wr_issue_ctl", 32'({bus.ram_en, bus.ram_we, bus.gnt_d, bus.busy, bus.done_d}), 32'b11110);
    check_output("wr_issue_addr", 32'(bus.ram_addr), 32'h040);
    check_output("wr_issue_data", bus.ram_wdata, 32'h0BADF00D);
    @(negedge Clock);
    check_output("wr_done_ctl", 32'({bus.ram_en, bus.ram_we, bus.gnt_d, bus.done_d}), 32'b0011);
    @(negedge Clock);
    check_output("wr_idle", 32'({bus.busy, bus.gnt_d, bus.done_d}), 32'b000);

    // Read latency with gnt_f held three cycles; a data request raised
    // mid-transaction and dropped before IDLE must be ignored.
    bus.req_f  = 1'b1;
    bus.addr_f = 9'h040;
    @(negedge Clock);
    push_exp(2'd0, 1'b0, 9'h040, 32'd0);
    clear_reqs();
    check_output("rd_issue_ctl", 32'({bus.ram_en, bus.ram_we, bus.gnt_f, bus.done_f}), 32'b1010);
    check_output("rd_issue_addr", 32'(bus.ram_addr), 32'h040);
    bus.req_d  = 1'b1;
    bus.addr_d = 9'h010;
    @(negedge Clock);
    check_output("rd_wait_ctl", 32'({bus.gnt_f, bus.done_f, bus.ram_en, bus.gnt_d}), 32'b1000);
    @(negedge Clock);
    check_output("rd_done_ctl", 32'({bus.gnt_f, bus.done_f, bus.gnt_d}), 32'b110);
    check_output("rd_done_rdata", bus.rdata, 32'h0BADF00D);
    bus.req_d = 1'b0;
    @(negedge Clock);
    check_output("rd_idle", 32'({bus.busy, bus.gnt_f}), 32'b00);
    @(negedge Clock);
    check_output("late_req_ignored", 32'(bus.busy), 32'd0);

    // Request and Run dropped during WAIT: the read still completes.
    Run        = 1'b1;
    bus.req_d  = 1'b1;
    bus.addr_d = 9'h1FF;
    @(negedge Clock);
    push_exp(2'd1, 1'b0, 9'h1FF, 32'd0);
    @(negedge Clock);
    bus.req_d = 1'b0;
    Run       = 1'b0;
    check_output("drop_wait_ctl", 32'({bus.gnt_d, bus.busy}), 32'b11);
    wait_idle();
    check_output("drop_rdata", bus.rdata, 32'hCAFEF00D);
    Run = 1'b1;

    // Starvation: D, F and X held high; X must win every 4th round.
    bus.req_d  = 1'b1;
    bus.addr_d = 9'h010;
    bus.req_f  = 1'b1;
    bus.addr_f = 9'h040;
    bus.req_x  = 1'b1;
    bus.addr_x = 9'h020;
    for (int i = 0; i < 8; i++) begin
      int n = 0;
      while (!bus.busy && n < 10) begin
        @(negedge Clock);
        n++;
      end
      if (!bus.busy) begin
        check_output("starve_timeout", 32'd0, 32'd1);
        break;
      end
      g = {bus.gnt_x, bus.gnt_d, bus.gnt_f};
      check_output($sformatf("starve_gnt%0d", i), 32'(g), 32'(starve_exp[i]));
      if (starve_exp[i] == 3'b100)
        push_exp(2'd2, 1'b0, 9'h020, 32'd0);
      else
        push_exp(2'd1, 1'b0, 9'h010, 32'd0);
      n = 0;
      while (bus.busy && n < 10) begin
        @(negedge Clock);
        n++;
      end
    end
    clear_reqs();
    wait_idle();

    // Reset during ISSUE of a write aborts it with no done pulse.
    bus.req_d   = 1'b1;
    bus.we_d    = 1'b1;
    bus.addr_d  = 9'h050;
    bus.wdata_d = 32'h11111111;
    @(negedge Clock);
    clear_reqs();
    check_output("rst_pre_we", 32'(bus.ram_we), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    check_output("rst_abort_ctl", 32'({bus.ram_en, bus.ram_we, bus.gnt_x, bus.gnt_d, bus.gnt_f,
                                       bus.busy, bus.done_d}), 32'd0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    check_output("rst_post_idle", 32'(bus.busy), 32'd0);
    check_output("rst_rdata", bus.rdata, 32'd0);
    check_output("rst_no_write", ram_word(9'h050), default_word(9'h050));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL expose parameters: ADDR_W, default 9, RAM word-address width; DATA_W, default 32, data width; XAGE_MAX, default 3, debug-port starvation limit.
REQ-002 SHALL have ports: Clock  in  1  system clock, all state on rising edge.
REQ-003 SHALL have ports: Reset  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: Run  in  1  CPU running; low = fetch/data ports masked.
REQ-005 SHALL have ports: req_f  in  1, addr_f  in  ADDR_W  fetch read request (read-only port).
REQ-006 SHALL have ports: req_d, we_d  in  1 each, addr_d  in  ADDR_W, wdata_d  in  DATA_W  load/store port.
REQ-007 SHALL have ports: req_x, we_x  in  1 each, addr_x  in  ADDR_W, wdata_x  in  DATA_W  debug/DMA port.
REQ-008 SHALL have ports: gnt_f, gnt_d, gnt_x  out  1 each  one-hot grant; done_f, done_d, done_x  out  1 each  completion pulses.
REQ-009 SHALL have ports: rdata  out  DATA_W  registered read data; busy  out  1  transaction in progress.
REQ-010 SHALL have ports: ram_en, ram_we  out  1 each, ram_addr  out  ADDR_W, ram_wdata  out  DATA_W, ram_rdata  in  DATA_W  single-port synchronous RAM, 1-cycle read latency.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; transitions: IDLE->ISSUE when an eligible request exists; ISSUE->WAIT on read, ISSUE->DONE on write; WAIT->DONE; DONE->IDLE unconditionally.
REQ-012 SHALL treat req_f/req_d as eligible only when Run=1; req_x always eligible.
REQ-013 SHALL arbitrate in IDLE by fixed priority D > F > X, except X wins outright when xage == XAGE_MAX.
REQ-014 SHALL keep 2-bit counter xage: +1 on each IDLE->ISSUE edge where req_x=1 and X not granted; saturate at XAGE_MAX; clear to 0 when X granted.
REQ-015 SHALL latch winner's address, we (0 for fetch) and wdata on the IDLE->ISSUE edge; later requester input changes SHALL NOT affect the transaction.
REQ-016 SHALL hold the winner's gnt_* high in ISSUE, WAIT, DONE; all gnt_* low in IDLE; never more than one gnt_* high.
REQ-017 SHALL drive ram_en=1 and latched ram_addr/ram_wdata only in ISSUE; ram_we=1 only in ISSUE for writes; all RAM outputs 0 otherwise.
REQ-018 SHALL capture ram_rdata into rdata on the WAIT->DONE edge; rdata held until next read capture; writes SHALL NOT alter rdata.
REQ-019 SHALL pulse the winner's done_* for exactly the DONE cycle.
REQ-020 SHALL give latency from accept edge k: write done in cycle after edge k+1; read done with valid rdata in cycle after edge k+2.
REQ-021 SHALL assert busy in ISSUE, WAIT, DONE.
REQ-022 SHALL complete an accepted transaction even if its req drops or Run falls mid-transaction.
REQ-023 SHALL re-arbitrate on return to IDLE; a requester holding req high through DONE receives a new transaction (back-to-back, 1 IDLE cycle gap).
REQ-024 SHALL ignore requests arriving outside IDLE until the next IDLE cycle.

Reset
REQ-025 SHALL, on Reset low, immediately force state IDLE, xage 0, rdata 0, and all outputs 0 (ram_we drops asynchronously, aborting any write in flight).
REQ-026 SHALL leave reset synchronously on the first rising Clock edge after Reset returns high, entering IDLE.

Verification
REQ-027 Run=1, req_d write addr 0x010 data 0xDEADBEEF -> ram_we=1 one cycle at 0x010; done_d in cycle after edge k+1.
REQ-028 req_f read addr 0x010 after REQ-027 -> rdata=0xDEADBEEF with done_f in cycle after edge k+2; gnt_f high 3 cycles.
REQ-029 req_d and req_f held high continuously, req_x high -> D granted first; X granted by no later than its 4th arbitration, then xage=0.
REQ-030 Run=0, req_f, req_d, req_x all high -> only X granted; F/D never granted until Run=1.
REQ-031 Reset low during ISSUE of a write -> ram_we, gnt_*, busy fall immediately; no done_* pulse; IDLE after release.
REQ-032 req_d dropped in WAIT of a read -> transaction completes, done_d pulses, rdata updated.
